// File: rtl/dcache_refill_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dcache_refill_ctrl_pkg : geometry and state encoding for the miss  |
// | sequencer.                                    Revision: 1.0        |
// +------------------------------------------------------------------+
package dcache_refill_ctrl_pkg;
  localparam int LOG_H  = 8;
  localparam int LOG_N  = 1;
  localparam int LOG_W  = 2;
  localparam int W      = 1 << LOG_W;
  localparam int LINE_W = W * 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_ADDR = 3'd1,
    ST_WB_DATA = 3'd2,
    ST_WB_RESP = 3'd3,
    ST_RD_ADDR = 3'd4,
    ST_RD_DATA = 3'd5,
    ST_DONE    = 3'd6
  } state_t;
endpackage
`default_nettype wire

// File: rtl/dcache_refill_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dcache_refill_ctrl_if : miss request, data RAM and bus bridge      |
// | signals of the refill sequencer.              Revision: 1.0        |
// +------------------------------------------------------------------+
interface dcache_refill_ctrl_if;
  import dcache_refill_ctrl_pkg::*;

  logic              miss_valid;
  logic              miss_ready;
  logic [LOG_H-1:0]  miss_index;
  logic [LOG_N-1:0]  miss_way;
  logic              miss_dirty;
  logic [31:0]       miss_wb_addr;
  logic [31:0]       miss_rf_addr;
  logic              done;
  logic              busy;
  logic              ram_we;
  logic [LOG_H-1:0]  ram_index;
  logic [LOG_N-1:0]  ram_way;
  logic [LOG_W-1:0]  ram_offset;
  logic [31:0]       ram_din;
  logic [LINE_W-1:0] ram_line;
  logic              rd_req;
  logic              rd_ready;
  logic [31:0]       rd_addr;
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic              rd_last;
  logic              wr_req;
  logic              wr_ready;
  logic [31:0]       wr_addr;
  logic              wr_dvalid;
  logic              wr_dready;
  logic [31:0]       wr_data;
  logic              wr_last;
  logic              wr_bvalid;

  modport master (
    input  miss_valid, miss_index, miss_way, miss_dirty, miss_wb_addr, miss_rf_addr,
    input  ram_line, rd_ready, rd_valid, rd_data, rd_last, wr_ready, wr_dready, wr_bvalid,
    output miss_ready, done, busy, ram_we, ram_index, ram_way, ram_offset, ram_din,
    output rd_req, rd_addr, wr_req, wr_addr, wr_dvalid, wr_data, wr_last
  );

  modport slave (
    output miss_valid, miss_index, miss_way, miss_dirty, miss_wb_addr, miss_rf_addr,
    output ram_line, rd_ready, rd_valid, rd_data, rd_last, wr_ready, wr_dready, wr_bvalid,
    input  miss_ready, done, busy, ram_we, ram_index, ram_way, ram_offset, ram_din,
    input  rd_req, rd_addr, wr_req, wr_addr, wr_dvalid, wr_data, wr_last
  );
endinterface
`default_nettype wire

// File: rtl/dcache_refill_ctrl_beat_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dcache_refill_ctrl_beat_cnt : word beat counter, wraps after W-1.  |
// |                                               Revision: 1.0        |
// +------------------------------------------------------------------+
module dcache_refill_ctrl_beat_cnt
  import dcache_refill_ctrl_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             resetn,
  input  wire logic             clr,
  input  wire logic             inc,
  output logic      [LOG_W-1:0] cnt,
  output logic                  last
);
  logic [LOG_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!resetn || clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + LOG_W'(1);
    end
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == LOG_W'(W - 1));
endmodule
`default_nettype wire

// File: rtl/dcache_refill_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dcache_refill_ctrl : single-miss sequencer -- optional victim      |
// | writeback, then W-beat refill into the data RAM. Revision: 1.0     |
// +------------------------------------------------------------------+
module dcache_refill_ctrl
  import dcache_refill_ctrl_pkg::*;
(
  input wire logic       clk,
  input wire logic       resetn,
  dcache_refill_ctrl_if.master bus
);
  state_t              r_state;
  logic                r_miss_ready;
  logic                r_done;
  logic                r_busy;
  logic                r_rd_req;
  logic [31:0]         r_rd_addr;
  logic                r_wr_req;
  logic [31:0]         r_wr_addr;
  logic                r_wr_dvalid;
  logic [LOG_H-1:0]    r_index;
  logic [LOG_N-1:0]    r_way;
  logic [31:0]         r_rf_addr;
  logic [LINE_W-1:0]   r_line;

  logic [LOG_W-1:0]    w_cnt;
  logic                w_cnt_last;
  logic                w_wr_beat;
  logic                w_rd_beat;
  logic                w_ram_we;
  logic                w_adv;

  assign w_wr_beat = (r_state == ST_WB_DATA) && r_wr_dvalid && bus.wr_dready;
  assign w_rd_beat = (r_state == ST_RD_DATA) && bus.rd_valid;

  // w_adv is high exactly in cycles where the state register changes.
  always_comb begin
    w_adv = 1'b0;
    case (r_state)
      ST_IDLE:    w_adv = bus.miss_valid && r_miss_ready;
      ST_WB_ADDR: w_adv = bus.wr_ready;
      ST_WB_DATA: w_adv = w_wr_beat && w_cnt_last;
      ST_WB_RESP: w_adv = bus.wr_bvalid;
      ST_RD_ADDR: w_adv = bus.rd_ready;
      ST_RD_DATA: w_adv = w_rd_beat && w_cnt_last;
      default:    w_adv = 1'b1;
    endcase
  end

  dcache_refill_ctrl_beat_cnt u_beat_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (w_adv),
    .inc    (w_wr_beat || w_rd_beat),
    .cnt    (w_cnt),
    .last   (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_miss_ready <= 1'b1;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_rd_req     <= 1'b0;
      r_rd_addr    <= '0;
      r_wr_req     <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_dvalid  <= 1'b0;
      r_index      <= '0;
      r_way        <= '0;
      r_rf_addr    <= '0;
      r_line       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_adv) begin
          r_miss_ready <= 1'b0;
          r_busy       <= 1'b1;
          r_index      <= bus.miss_index;
          r_way        <= bus.miss_way;
          r_rf_addr    <= bus.miss_rf_addr;
          r_line       <= bus.ram_line;   // RAM is addressed by miss_* this cycle
          if (bus.miss_dirty) begin
            r_state   <= ST_WB_ADDR;
            r_wr_req  <= 1'b1;
            r_wr_addr <= bus.miss_wb_addr;
          end else begin
            r_state   <= ST_RD_ADDR;
            r_rd_req  <= 1'b1;
            r_rd_addr <= bus.miss_rf_addr;
          end
        end
        ST_WB_ADDR: if (w_adv) begin
          r_state     <= ST_WB_DATA;
          r_wr_req    <= 1'b0;
          r_wr_dvalid <= 1'b1;
        end
        ST_WB_DATA: if (w_adv) begin
          r_state     <= ST_WB_RESP;
          r_wr_dvalid <= 1'b0;
        end
        ST_WB_RESP: if (w_adv) begin
          r_state   <= ST_RD_ADDR;
          r_rd_req  <= 1'b1;
          r_rd_addr <= r_rf_addr;
        end
        ST_RD_ADDR: if (w_adv) begin
          r_state  <= ST_RD_DATA;
          r_rd_req <= 1'b0;
        end
        ST_RD_DATA: if (w_adv) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state      <= ST_IDLE;
          r_miss_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_miss_ready <= 1'b1;
          r_busy       <= 1'b0;
          r_rd_req     <= 1'b0;
          r_wr_req     <= 1'b0;
          r_wr_dvalid  <= 1'b0;
        end
      endcase
    end
  end

  // Gated by resetn so an aborting reset cycle cannot commit a stray beat.
  assign w_ram_we       = resetn && w_rd_beat;

  assign bus.miss_ready = r_miss_ready;
  assign bus.done       = r_done;
  assign bus.busy       = r_busy;
  assign bus.ram_we     = w_ram_we;
  assign bus.ram_index  = (r_state == ST_IDLE) ? bus.miss_index : r_index;
  assign bus.ram_way    = (r_state == ST_IDLE) ? bus.miss_way : r_way;
  assign bus.ram_offset = w_cnt;
  assign bus.ram_din    = w_ram_we ? bus.rd_data : 32'd0;
  assign bus.rd_req     = r_rd_req;
  assign bus.rd_addr    = r_rd_addr;
  assign bus.wr_req     = r_wr_req;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_dvalid  = r_wr_dvalid;
  assign bus.wr_data    = r_line[int'(w_cnt) * 32 +: 32];
  assign bus.wr_last    = r_wr_dvalid && w_cnt_last;

  a_rd_last: assert property (@(posedge clk) disable iff (!resetn)
    w_rd_beat |-> (bus.rd_last == w_cnt_last));
endmodule
`default_nettype wire
